// File: rtl/fp_normalize_round_if.sv
// Result bus between the add/multiply cores and the normalize/round/pack back end.
interface fp_normalize_round_if #(
    parameter int FRAC_WIDTH = 24,
    parameter int EXP_WIDTH  = 8
);
    logic                              validIn;
    logic                              signIn;
    logic signed [EXP_WIDTH+1:0]       expIn;
    logic [FRAC_WIDTH+2:0]             mantIn;
    logic [1:0]                        specialIn;
    logic [EXP_WIDTH+FRAC_WIDTH-1:0]   dataOut;
    logic                              validOut;

    modport master (output validIn, signIn, expIn, mantIn, specialIn,
                    input  dataOut, validOut);
    modport slave  (input  validIn, signIn, expIn, mantIn, specialIn,
                    output dataOut, validOut);
endinterface

// File: rtl/fp_normalize_round.sv
// Normalize, round-to-nearest-even and pack an unnormalized FP result.
// Input register, normalize, round, pack: validOut three edges after capture.
module fp_normalize_round #(
    parameter int FRAC_WIDTH = 24,
    parameter int EXP_WIDTH  = 8
) (
    input  logic                clkIn,
    input  logic                rstIn,
    fp_normalize_round_if.slave bus
);
    localparam int MW = FRAC_WIDTH + 3;
    localparam int NW = FRAC_WIDTH + 2;
    localparam int XW = EXP_WIDTH + 3;
    localparam int LW = $clog2(MW);
    localparam int DW = EXP_WIDTH + FRAC_WIDTH;
    localparam logic signed [XW-1:0] EMAX_X = XW'((1 << EXP_WIDTH) - 1);
    localparam logic signed [XW-1:0] ZERO_X = '0;

    // One extra exponent bit keeps shifts and round carries from wrapping.
    logic [3:0]                vld_q;
    logic                      in_sign_q, s1_sign_q, s2_sign_q;
    logic signed [XW-1:0]      in_exp_q, s1_exp_q, s2_exp_q;
    logic [MW-1:0]             in_mant_q;
    logic [1:0]                in_spec_q, s1_spec_q, s2_spec_q;
    logic [NW-1:0]             s1_mant_q;
    logic [FRAC_WIDTH-2:0]     s2_frac_q;
    logic [DW-1:0]             data_q;

    logic [LW-1:0]             lz_d;
    logic [NW-1:0]             norm_mant_d;
    logic signed [XW-1:0]      norm_exp_d;
    logic [1:0]                norm_spec_d;
    logic                      round_up_d;
    logic [FRAC_WIDTH:0]       sum_d;
    logic signed [XW-1:0]      rnd_exp_d;
    logic [DW-1:0]             pack_d;

    always_comb begin
        lz_d = LW'(NW);
        for (int i = 0; i < NW; i++)
            if (in_mant_q[i]) lz_d = LW'(NW - 1 - i);
        if (in_mant_q[MW-1]) begin
            norm_mant_d = {in_mant_q[MW-1:2], in_mant_q[1] | in_mant_q[0]};
            norm_exp_d  = in_exp_q + XW'(1);
        end else begin
            norm_mant_d = in_mant_q[NW-1:0] << lz_d;
            norm_exp_d  = in_exp_q - XW'(lz_d);
        end
        norm_spec_d = in_spec_q;
        if (in_spec_q == 2'b00 && in_mant_q == '0) norm_spec_d = 2'b01;
    end

    always_comb begin
        round_up_d = s1_mant_q[1] & (s1_mant_q[0] | s1_mant_q[2]);
        sum_d      = {1'b0, s1_mant_q[NW-1:2]} + (FRAC_WIDTH+1)'(round_up_d);
        rnd_exp_d  = s1_exp_q + XW'(sum_d[FRAC_WIDTH]);
    end

    always_comb begin
        pack_d = {s2_sign_q, s2_exp_q[EXP_WIDTH-1:0], s2_frac_q};
        case (s2_spec_q)
            2'b11:   pack_d = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(FRAC_WIDTH-2){1'b0}}};
            2'b10:   pack_d = {s2_sign_q, {EXP_WIDTH{1'b1}}, {(FRAC_WIDTH-1){1'b0}}};
            2'b01:   pack_d = {s2_sign_q, {(DW-1){1'b0}}};
            default: begin
                if (s2_exp_q >= EMAX_X)
                    pack_d = {s2_sign_q, {EXP_WIDTH{1'b1}}, {(FRAC_WIDTH-1){1'b0}}};
                else if (s2_exp_q <= ZERO_X)
                    pack_d = {s2_sign_q, {(DW-1){1'b0}}};
            end
        endcase
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            vld_q     <= '0;
            data_q    <= '0;
            in_sign_q <= 1'b0;
            in_exp_q  <= '0;
            in_mant_q <= '0;
            in_spec_q <= '0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= '0;
            s1_mant_q <= '0;
            s1_spec_q <= '0;
            s2_sign_q <= 1'b0;
            s2_exp_q  <= '0;
            s2_frac_q <= '0;
            s2_spec_q <= '0;
        end else begin
            vld_q <= {vld_q[2:0], bus.validIn};
            if (bus.validIn) begin
                in_sign_q <= bus.signIn;
                in_exp_q  <= {bus.expIn[EXP_WIDTH+1], bus.expIn};
                in_mant_q <= bus.mantIn;
                in_spec_q <= bus.specialIn;
            end
            if (vld_q[0]) begin
                s1_sign_q <= in_sign_q;
                s1_exp_q  <= norm_exp_d;
                s1_mant_q <= norm_mant_d;
                s1_spec_q <= norm_spec_d;
            end
            if (vld_q[1]) begin
                s2_sign_q <= s1_sign_q;
                s2_exp_q  <= rnd_exp_d;
                s2_frac_q <= sum_d[FRAC_WIDTH-2:0];
                s2_spec_q <= s1_spec_q;
            end
            if (vld_q[2]) data_q <= pack_d;
        end
    end

    assign bus.dataOut  = data_q;
    assign bus.validOut = vld_q[3];
endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed table, streaming/reset sequences and randomized traffic against an arithmetic model.
module tb_fp_normalize_round;
    localparam int F = 24;
    localparam int E = 8;

    typedef struct {
        string       name;
        logic        s;
        int          e;
        logic [26:0] m;
        logic [1:0]  sp;
        logic [31:0] want;
    } vec_t;

    logic clk, rst;
    int   n_tests, n_fail;
    bit   mon_en;
    logic [31:0] expq[$];
    vec_t tbl[15];

    fp_normalize_round_if #(.FRAC_WIDTH(F), .EXP_WIDTH(E)) bus ();
    fp_normalize_round #(.FRAC_WIDTH(F), .EXP_WIDTH(E)) dut (
        .clkIn(clk), .rstIn(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Round the exact value M * 2^(e-bias-(F+1)) to F significant bits.
    function automatic logic [31:0] model(input logic s, input int e, input logic [26:0] m,
                                          input logic [1:0] sp);
        longint M, kept;
        int p, d, ex;
        bit g, st;
        M = longint'(m);
        if (sp == 2'b11) return {1'b0, {E{1'b1}}, 1'b1, {(F-2){1'b0}}};
        if (sp == 2'b10) return {s, {E{1'b1}}, {(F-1){1'b0}}};
        if (sp == 2'b01 || M == 0) return {s, 31'd0};
        p = 26;
        while (((M >> p) & 1) == 0) p--;
        ex = e + p - (F + 1);
        d  = p - (F - 1);
        if (d > 0) begin
            kept = M >> d;
            g    = ((M >> (d - 1)) & 1) != 0;
            st   = (d > 1) ? ((M & ((64'd1 << (d - 1)) - 1)) != 0) : 1'b0;
        end else begin
            kept = M << (-d);
            g    = 1'b0;
            st   = 1'b0;
        end
        if (g && (st || (kept & 1) != 0)) kept++;
        if (kept == (64'd1 << F)) begin
            kept = kept >> 1;
            ex++;
        end
        if (ex >= (1 << E) - 1) return {s, {E{1'b1}}, {(F-1){1'b0}}};
        if (ex <= 0) return {s, 31'd0};
        return {s, ex[E-1:0], kept[F-2:0]};
    endfunction

    task automatic drive(input logic s, input int e, input logic [26:0] m, input logic [1:0] sp);
        bus.validIn   = 1'b1;
        bus.signIn    = s;
        bus.expIn     = 10'(e);
        bus.mantIn    = m;
        bus.specialIn = sp;
    endtask

    task automatic apply_one(input vec_t v);
        int lat;
        drive(v.s, v.e, v.m, v.sp);
        tick();
        bus.validIn = 1'b0;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!bus.validOut && lat < 8);
        check({"lat_", v.name}, 32'(lat), 32'd3);
        check(v.name, bus.dataOut, v.want);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && bus.validOut) begin
            if (expq.size() == 0) check("stream_spurious", 32'd1, 32'd0);
            else check("stream", bus.dataOut, expq.pop_front());
        end
    end

    initial begin
        logic [31:0] seq_exp[8];
        logic [26:0] rm;
        int          re;
        logic [1:0]  rsp;
        logic        rs;
        n_tests = 0; n_fail = 0; mon_en = 1'b0;
        tbl[0]  = '{"basic",     1'b0, 127, 27'h2000000, 2'b00, 32'h3F800000};
        tbl[1]  = '{"carry",     1'b0, 127, 27'h4000000, 2'b00, 32'h40000000};
        tbl[2]  = '{"cancel",    1'b0, 127, 27'h0000004, 2'b00, 32'h34000000};
        tbl[3]  = '{"tie_even",  1'b0, 127, 27'h2000002, 2'b00, 32'h3F800000};
        tbl[4]  = '{"tie_odd",   1'b0, 127, 27'h2000006, 2'b00, 32'h3F800002};
        tbl[5]  = '{"rnd_carry", 1'b0, 127, 27'h3FFFFFE, 2'b00, 32'h40000000};
        tbl[6]  = '{"ovf",       1'b0, 254, 27'h4000000, 2'b00, 32'h7F800000};
        tbl[7]  = '{"unf",       1'b0, 0,   27'h2000000, 2'b00, 32'h00000000};
        tbl[8]  = '{"neg_zero",  1'b1, 127, 27'h0000000, 2'b00, 32'h80000000};
        tbl[9]  = '{"nan",       1'b1, 127, 27'h2000000, 2'b11, 32'h7FC00000};
        tbl[10] = '{"neg_inf",   1'b1, 127, 27'h2000000, 2'b10, 32'hFF800000};
        tbl[11] = '{"above_half",1'b0, 127, 27'h2000003, 2'b00, 32'h3F800001};
        tbl[12] = '{"neg_exp",   1'b1, -5,  27'h2000000, 2'b00, 32'h80000000};
        tbl[13] = '{"big_exp",   1'b0, 400, 27'h2000000, 2'b00, 32'h7F800000};
        tbl[14] = '{"max_norm",  1'b0, 254, 27'h3FFFFFC, 2'b00, 32'h7F7FFFFF};

        bus.validIn = 1'b0; bus.signIn = 1'b0; bus.expIn = '0;
        bus.mantIn = '0; bus.specialIn = '0;
        rst = 1'b1;
        tick(); tick();
        check("rst_valid", 32'(bus.validOut), 32'd0);
        check("rst_data", bus.dataOut, 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) apply_one(tbl[i]);

        // Eight back-to-back samples, then confirm the output holds.
        for (int c = 0; c < 12; c++) begin
            if (c < 8) begin
                rs = 1'(c & 1); re = 120 + c; rm = 27'h2000000 | 27'(c * 37 + 5);
                seq_exp[c] = model(rs, re, rm, 2'b00);
                drive(rs, re, rm, 2'b00);
            end else bus.validIn = 1'b0;
            tick();
            if (c < 3) check("b2b_idle", 32'(bus.validOut), 32'd0);
            else if (c < 11) begin
                check("b2b_valid", 32'(bus.validOut), 32'd1);
                check("b2b_data", bus.dataOut, seq_exp[c-3]);
            end else begin
                check("b2b_end", 32'(bus.validOut), 32'd0);
                check("b2b_hold", bus.dataOut, seq_exp[7]);
            end
        end

        mon_en = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 8) begin
                case ($urandom_range(0, 3))
                    0: rm = 27'($urandom);
                    1: rm = 27'($urandom) >> $urandom_range(0, 26);
                    2: rm = {2'b01, 25'($urandom)};
                    default: rm = {2'b01, 23'($urandom), 2'b10};
                endcase
                re  = int'($urandom_range(0, 340)) - 40;
                rsp = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
                rs  = 1'($urandom);
                expq.push_back(model(rs, re, rm, rsp));
                drive(rs, re, rm, rsp);
            end else bus.validIn = 1'b0;
            tick();
        end
        bus.validIn = 1'b0;
        repeat (6) tick();
        mon_en = 1'b0;
        check("stream_drained", 32'(expq.size()), 32'd0);

        // Two samples in flight when reset hits must vanish.
        drive(1'b0, 127, 27'h2000000, 2'b00); tick();
        drive(1'b0, 128, 27'h2000000, 2'b00); tick();
        rst = 1'b1; bus.validIn = 1'b1;
        tick();
        check("rst_flight_valid", 32'(bus.validOut), 32'd0);
        check("rst_flight_data", bus.dataOut, 32'd0);
        rst = 1'b0; bus.validIn = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("rst_dropped", 32'(bus.validOut), 32'd0);
        end
        check("rst_data_after", bus.dataOut, 32'd0);
        apply_one(tbl[1]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
